seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multicycle signed divider (MIPS DIV) feeding the HI/LO datapath of the CPU.
//  Takes the A and B register outputs, does restoring division over 32 iterations,
//  and presents remainder on hi_out and quotient on lo_out.
//  The control unit starts it, waits on done, and uses div_zero to raise the divide-by-zero exception.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (log2 counter sized from it)
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high; forces IDLE and clears all outputs
//  start     in   1      1-cycle request; operands sampled on the same edge
//  a_in      in   WIDTH  dividend (two's complement), from register A
//  b_in      in   WIDTH  divisor (two's complement), from register B
//  hi_out    out  WIDTH  remainder of last successful division
//  lo_out    out  WIDTH  quotient of last successful division
//  busy      out  1      operation in progress
//  done      out  1      1-cycle pulse: result (or div_zero) valid
//  div_zero  out  1      1-cycle pulse coincident with done when b_in was 0
// BEHAVIOUR
//  Reset: state=IDLE; hi_out=lo_out=0; busy=done=div_zero=0; counter=0.
//  Clock and reset: one clock, clk; reset asynchronous, active-high.
//  States: IDLE, RUN, FIN.
//  IDLE, start=1 at edge E0: latch sign(a), sign(b), |a|, |b|; clear partial remainder.
//   - b_in==0: stay IDLE; done=1 and div_zero=1 for cycle after E0; hi_out/lo_out unchanged.
//   - else: go RUN; busy=1 from E0; count=0.
//  RUN: one restoring step per edge, WIDTH steps at E1..E32.
//   - Step: shift {rem,quot} left 1; trial = rem - |b|.
//   - If trial>=0 (unsigned compare): rem=trial, quot[0]=1; else quot[0]=0.
//   - After step WIDTH-1: go FIN.
//  FIN, edge E33:
//   - lo_out = (sa^sb) ? -quot : quot.
//   - hi_out = sa ? -rem : rem.
//   - done=1 for exactly one cycle; busy=0; go IDLE.
//  Latency: done visible 33 cycles after the start edge; back-to-back start accepted on the edge done is high.
//  Arithmetic: quotient truncates toward zero; remainder takes the dividend's sign.
//   - |x| of -2^31 is 0x80000000, handled as unsigned magnitude.
//   - -2^31 / -1 wraps: lo_out=0x80000000, hi_out=0, no flag.
//  start while busy=1: ignored; in-flight operation and operands unaffected.
//  hi_out/lo_out change only at FIN; they hold their value through IDLE and RUN.
//  done and div_zero are registered and never high in the same cycle as busy.
//  Reset during RUN/FIN: abort immediately; outputs return to reset values; no done pulse.
// TESTING
//  1. 100 / 7 -> after 33 cycles: done=1, lo=14, hi=2; busy high cycles 0..32 only.
//  2. Signs: -100/7 -> lo=-14 (0xFFFFFFF2), hi=-2; 100/-7 -> lo=-14, hi=2; -100/-7 -> lo=14, hi=-2.
//  3. Divide by zero: 55/0 -> next cycle done=1, div_zero=1, busy never high; hi/lo keep prior 2/14.
//  4. Overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//  5. Boundaries: 0/5 -> lo=0, hi=0; 3/0x7FFFFFFF -> lo=0, hi=3.
//  6. Start spam during RUN ignored (result of the first op only); async reset at cycle 10 -> outputs 0, no done.

Source files
------------

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multicycle signed divider for the HI/LO datapath. Operands are converted to
// unsigned magnitudes, divided by a restoring shift/subtract loop (one bit per
// clock), and the signs are re-applied at the end: the quotient truncates
// toward zero and the remainder takes the dividend's sign.
// A zero divisor is answered one cycle after start with done+div_zero and
// leaves hi_out/lo_out untouched.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t             state_r;
    state_t             nextState_s;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH-1:0]   divMag_r;
    logic               signA_r;
    logic               signB_r;
    logic [WIDTH-1:0]   shifted_s;
    logic [WIDTH:0]     trial_s;
    logic               bIsZero_s;

    // Two's complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) unchanged.
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] x);
        if (x[WIDTH-1]) begin
            return negate(x);
        end else begin
            return x;
        end
    endfunction

    // Negate only when the requested sign is negative.
    function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] x,
                                                   input logic neg);
        if (neg) begin
            return negate(x);
        end else begin
            return x;
        end
    endfunction

    // One restoring step: shift the next dividend bit into the remainder and
    // try to subtract the divisor magnitude. The extra MSB of trial_s is the
    // borrow, so trial_s[WIDTH]==0 means the subtraction fits.
    always_comb begin
        shifted_s = {rem_r[WIDTH-2:0], quot_r[WIDTH-1]};
        trial_s   = {1'b0, shifted_s} - {1'b0, divMag_r};
        bIsZero_s = (b_in == {WIDTH{1'b0}});
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; a start while not IDLE is simply not looked at.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !bIsZero_s) begin
                    nextState_s = RUN;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == CNT_W'(WIDTH - 1)) begin
                    nextState_s = FIN;
                end else begin
                    nextState_s = RUN;
                end
            end
            FIN:     nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Datapath and registered status/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quot_r   <= {WIDTH{1'b0}};
            divMag_r <= {WIDTH{1'b0}};
            signA_r  <= 1'b0;
            signB_r  <= 1'b0;
            hi_out   <= {WIDTH{1'b0}};
            lo_out   <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        signA_r  <= a_in[WIDTH-1];
                        signB_r  <= b_in[WIDTH-1];
                        quot_r   <= absVal(a_in);
                        divMag_r <= absVal(b_in);
                        rem_r    <= {WIDTH{1'b0}};
                        count_r  <= {CNT_W{1'b0}};
                        if (bIsZero_s) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (!trial_s[WIDTH]) begin
                        rem_r <= trial_s[WIDTH-1:0];
                    end else begin
                        rem_r <= shifted_s;
                    end
                    quot_r  <= {quot_r[WIDTH-2:0], ~trial_s[WIDTH]};
                    count_r <= count_r + CNT_W'(1);
                end
                FIN: begin
                    lo_out <= applySign(quot_r, signA_r ^ signB_r);
                    hi_out <= applySign(rem_r, signA_r);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Directed vectors with hand-computed results. Each issued division pushes
// its expected result and completion cycle into a scoreboard queue; a
// monitor pops and compares whenever done is presented.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cycle = 32'd0;
    int          nChecks = 0;
    int          nFail = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (done && busy) check("done_with_busy", 32'd1, 32'd0);
            if (div_zero && !done) check("div_zero_without_done", 32'd1, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("lo_out", lo_out, e.lo);
                    check("hi_out", hi_out, e.hi);
                    check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    check("latency_cycle", cycle, e.cyc);
                end
            end
        end
    end

    // Issue one division, record its expectation, wait (bounded) for done.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expLo, input logic [31:0] expHi,
                          input logic expDz, input bit now, input bit spam);
        exp_t e;
        int   busyCnt;
        bit   seen;
        if (!now) @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        e.lo  = expLo;
        e.hi  = expHi;
        e.dz  = expDz;
        e.cyc = cycle + 32'd1 + (expDz ? 32'd0 : 32'd33);
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        busyCnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                seen = 1'b1;
            end else if (spam && busy) begin
                start = 1'b1;
                a_in  = 32'd999;
                b_in  = 32'd3;
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", busyCnt, expDz ? 32'd0 : 32'd33);
    endtask

    initial begin
        int doneCnt;
        reset = 1'b1;
        start = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;

        // Basic and sign combinations
        runDiv(32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0);
        runDiv(32'd55,         32'd0,        32'd14,       32'd2,        1'b1, 1'b0, 1'b0);
        runDiv(32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        runDiv(32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 1'b0);
        runDiv(32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        // Overflow wrap and boundaries
        runDiv(32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b0, 1'b0);
        runDiv(32'd0,          32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 1'b0);
        runDiv(32'd3,          32'h7FFFFFFF, 32'd0,        32'd3,        1'b0, 1'b0, 1'b0);
        runDiv(32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0);
        runDiv(32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        runDiv(32'h80000000,   32'd1,        32'h80000000, 32'd0,        1'b0, 1'b0, 1'b0);
        // Start spam during RUN; then back-to-back start on the done cycle
        runDiv(32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b1);
        runDiv(32'd7,          32'd100,      32'd0,        32'd7,        1'b0, 1'b1, 1'b0);
        runDiv(32'd1000,       32'd0,        32'd0,        32'd7,        1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        a_in  = 32'd100;
        b_in  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_hi", hi_out, 32'd0);
        check("midrst_lo", lo_out, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        check("no_done_after_reset", doneCnt, 32'd0);

        // Recovery after reset
        runDiv(32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
